xpar_uart: RTL and testbench
============================

Name: xpar_uart

Overview:
- Memory-mapped 8N1 UART peripheral on the core's external parallel interface; consumes par_addr/par_out/par_we/par_re and produces par_in.
- Contains a TX FIFO, a single-entry RX holding register, status/error flags and a programmable baud divisor.
- Gives the controller serial console I/O without user-module changes.

Parameters:
- DATA_W, 32, parallel bus data width (must be >= 16).
- ADDR_W, 13, core address width; the bus address is ADDR_W-1 bits.
- TX_DEPTH, 4, TX FIFO entries (power of 2, >= 2).
- DEFAULT_DIV, 434, reset baud divisor in clk cycles per bit.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- par_addr  in  ADDR_W-1  register address; only bits [1:0] decoded, upper bits ignored (aliasing).
- par_wdata  in  DATA_W  write data.
- par_we  in  1  write strobe, one cycle per access.
- par_re  in  1  read strobe, one cycle per access.
- par_rdata  out  DATA_W  read data.
- uart_tx  out  1  serial output, idle high.
- uart_rx  in  1  asynchronous serial input.
- rx_irq  out  1  equals rx_valid.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst): sampled only on the rising edge of clk.
- Reset values:
  - uart_tx=1, rx_irq=0, FIFO empty.
  - rx_valid=0, overrun=0, frame_err=0, DIV=DEFAULT_DIV.
  - Both FSMs IDLE; synchronizer flops=1.
  - Reset mid-frame aborts immediately; uart_tx is high the cycle after the reset edge.
- Register map (addr[1:0]):
  - 0 TXDATA: W pushes wdata[7:0] into the FIFO; push while full is silently dropped. Reads 0.
  - 1 RXDATA: R returns {rx_valid at bit 8, rx_byte at [7:0]}, zero-extended. A read with par_re=1 clears rx_valid at that edge. Writes ignored.
  - 2 STATUS: R returns bit0 tx_busy (FSM not IDLE or FIFO non-empty), bit1 fifo_full, bit2 rx_valid, bit3 overrun, bit4 frame_err. Writing 1 to bit3 or bit4 clears that flag. Other bits read 0.
  - 3 DIV: R/W, 16 bits in [15:0]. A written value < 2 is stored as 2.
- Read path: par_rdata is purely combinational from par_addr and state, valid in the same cycle regardless of par_re. Side effects occur only on the edge where par_re=1.
- par_we and par_re are never asserted together; behaviour in that case is undefined.
- Baud: DIV is latched into a per-FSM copy at each frame start. A DIV write mid-frame affects only the next frame.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - In IDLE with the FIFO non-empty: pop the head and go to START on the next edge; uart_tx is registered.
  - A write to an empty FIFO at edge N gives uart_tx=0 from edge N+1.
  - Each bit lasts exactly DIV cycles; data is sent LSB first; the stop bit is 1.
  - At the end of STOP, if the FIFO is non-empty go straight to START with no idle gap. A frame is exactly 10*DIV cycles.
  - A push and a pop in the same cycle on a full FIFO: the pop frees an entry first, so the push is accepted.
- RX path: two-flop synchronizer on uart_rx.
  - IDLE: on synced=0, count DIV/2 (integer division) cycles. If still 0, enter DATA; otherwise return to IDLE (glitch rejected).
  - DATA: sample every DIV cycles, 8 bits LSB first, then sample the stop bit.
  - Stop=1: load rx_byte and set rx_valid. If rx_valid was already 1, set overrun and overwrite the byte.
  - Stop=0: discard the byte, set frame_err, leave rx_valid unchanged.
  - Then return to IDLE, which waits for synced=1 before re-arming.
  - A byte completing on the same edge as an RXDATA read: rx_valid ends 1 with the new byte, and overrun is not set.
- Flag clear vs. set on the same edge: set wins.

Test Plan:
- Reset, write DIV=4, write TXDATA=0xA5 -> uart_tx goes 0 one cycle after the write edge, then shows bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles; frame is 40 cycles; STATUS bit0 drops to 0 after it.
- DIV=4, write 5 bytes back-to-back (0x01..0x05) with TX busy -> STATUS bit1 reads 1 after the 4th queued byte; the 5th is dropped or accepted per the pop timing above; the transmitted stream is contiguous frames with no idle gap.
- Loop uart_tx to uart_rx, DIV=8, send 0x3C -> RXDATA reads 0x13C and rx_irq=1; the read clears it, so a second read returns 0x03C.
- Send 0x11 then 0x22 without reading -> RXDATA=0x122, STATUS bit3=1; write STATUS 0x08 -> bit3 reads 0.
- Drive an rx frame with stop bit=0 -> rx_valid unchanged, STATUS bit4=1; a 1-cycle low glitch on uart_rx with DIV=8 -> no reception.
- Assert rst mid-TX frame -> uart_tx=1 the next cycle, FIFO empty, DIV=434, all flags 0; write DIV=0 -> reads back 2.

Source files
------------

// File: rtl/xpar_uart.sv
// rtl/xpar_uart.sv - memory-mapped 8N1 UART with TX FIFO, RX holding register and baud divisor
module xpar_uart #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 13,
    parameter int TX_DEPTH    = 4,
    parameter int DEFAULT_DIV = 434
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-2:0] par_addr,
    input  logic [DATA_W-1:0] par_wdata,
    input  logic              par_we,
    input  logic              par_re,
    output logic [DATA_W-1:0] par_rdata,
    output logic              uart_tx,
    input  logic              uart_rx,
    output logic              rx_irq
);
    localparam int AW = $clog2(TX_DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    logic [1:0]    reg_sel;
    logic          wr_tx, wr_status, wr_div, rd_rx;
    logic [15:0]   div_reg;

    logic [7:0]    fifo_mem [TX_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_cnt;
    logic          fifo_full, fifo_empty, fifo_push;

    tx_state_t     tx_state, tx_state_n;
    logic [15:0]   tx_cnt, tx_div;
    logic [7:0]    tx_shift;
    logic [2:0]    tx_bit;
    logic          tx_tick, tx_pop, tx_line_n, tx_busy;

    rx_state_t     rx_state, rx_state_n;
    logic          rx_s1, rx_sync;
    logic [15:0]   rx_cnt, rx_div;
    logic [7:0]    rx_shift, rx_byte;
    logic [2:0]    rx_bit;
    logic          rx_tick, rx_half_tick, rx_done_ok, rx_done_bad;
    logic          rx_valid, overrun, frame_err;

    logic          unused_bits;
    assign unused_bits = ^{par_addr[ADDR_W-2:2], par_wdata[DATA_W-1:16]};

    assign reg_sel   = par_addr[1:0];
    assign wr_tx     = par_we && (reg_sel == 2'd0);
    assign wr_status = par_we && (reg_sel == 2'd2);
    assign wr_div    = par_we && (reg_sel == 2'd3);
    assign rd_rx     = par_re && (reg_sel == 2'd1);

    assign fifo_full  = (fifo_cnt == (AW+1)'(TX_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    // A pop on the same edge frees a slot, so a push into a full FIFO still lands
    assign fifo_push  = wr_tx && (!fifo_full || tx_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_push) begin
                fifo_mem[wr_ptr] <= par_wdata[7:0];
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (tx_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({fifo_push, tx_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign tx_tick = (tx_cnt == tx_div - 16'd1);
    assign tx_busy = (tx_state != TX_IDLE) || !fifo_empty;

    always_comb begin
        tx_state_n = tx_state;
        tx_pop     = 1'b0;
        tx_line_n  = uart_tx;
        case (tx_state)
            TX_IDLE: if (!fifo_empty) begin
                tx_pop     = 1'b1;
                tx_state_n = TX_START;
                tx_line_n  = 1'b0;
            end
            TX_START: if (tx_tick) begin
                tx_state_n = TX_DATA;
                tx_line_n  = tx_shift[0];
            end
            TX_DATA: if (tx_tick) begin
                if (tx_bit == 3'd7) begin
                    tx_state_n = TX_STOP;
                    tx_line_n  = 1'b1;
                end else begin
                    tx_line_n  = tx_shift[1];
                end
            end
            TX_STOP: if (tx_tick) begin
                if (!fifo_empty) begin
                    tx_pop     = 1'b1;
                    tx_state_n = TX_START;
                    tx_line_n  = 1'b0;
                end else begin
                    tx_state_n = TX_IDLE;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            uart_tx  <= 1'b1;
            tx_cnt   <= '0;
            tx_div   <= 16'(DEFAULT_DIV);
            tx_shift <= '0;
            tx_bit   <= '0;
        end else begin
            tx_state <= tx_state_n;
            uart_tx  <= tx_line_n;
            if (tx_pop) begin
                tx_shift <= fifo_mem[rd_ptr];
                tx_div   <= div_reg;
                tx_cnt   <= '0;
                tx_bit   <= '0;
            end else if (tx_state != TX_IDLE) begin
                if (tx_tick) begin
                    tx_cnt <= '0;
                    if (tx_state == TX_DATA) begin
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_bit   <= tx_bit + 3'd1;
                    end
                end else begin
                    tx_cnt <= tx_cnt + 16'd1;
                end
            end
        end
    end

    assign rx_tick      = (rx_cnt == rx_div - 16'd1);
    assign rx_half_tick = (rx_cnt == (rx_div >> 1) - 16'd1);

    always_comb begin
        rx_state_n  = rx_state;
        rx_done_ok  = 1'b0;
        rx_done_bad = 1'b0;
        case (rx_state)
            RX_IDLE:  if (!rx_sync) rx_state_n = RX_START;
            RX_START: if (rx_half_tick) rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_state_n = RX_STOP;
            RX_STOP: if (rx_tick) begin
                rx_state_n  = RX_WAIT;
                rx_done_ok  = rx_sync;
                rx_done_bad = !rx_sync;
            end
            RX_WAIT:  if (rx_sync) rx_state_n = RX_IDLE;
            default:  rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_sync  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_div   <= 16'(DEFAULT_DIV);
            rx_shift <= '0;
            rx_bit   <= '0;
        end else begin
            rx_s1    <= uart_rx;
            rx_sync  <= rx_s1;
            rx_state <= rx_state_n;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    rx_bit <= '0;
                    rx_div <= div_reg;
                end
                RX_START: rx_cnt <= rx_half_tick ? 16'd0 : rx_cnt + 16'd1;
                RX_DATA, RX_STOP: begin
                    if (rx_tick) begin
                        rx_cnt <= '0;
                        if (rx_state == RX_DATA) begin
                            rx_shift <= {rx_sync, rx_shift[7:1]};
                            rx_bit   <= rx_bit + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: rx_cnt <= '0;
            endcase
        end
    end

    // A completing byte outranks a same-edge RXDATA read, and never counts as overrun then
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            rx_byte   <= '0;
            div_reg   <= 16'(DEFAULT_DIV);
        end else begin
            if (rx_done_ok) begin
                rx_valid <= 1'b1;
                rx_byte  <= rx_shift;
            end else if (rd_rx) begin
                rx_valid <= 1'b0;
            end
            if (rx_done_ok && rx_valid && !rd_rx)
                overrun <= 1'b1;
            else if (wr_status && par_wdata[3])
                overrun <= 1'b0;
            if (rx_done_bad)
                frame_err <= 1'b1;
            else if (wr_status && par_wdata[4])
                frame_err <= 1'b0;
            if (wr_div)
                div_reg <= (par_wdata[15:0] < 16'd2) ? 16'd2 : par_wdata[15:0];
        end
    end

    always_comb begin
        par_rdata = '0;
        case (reg_sel)
            2'd1:    par_rdata[8:0]  = {rx_valid, rx_byte};
            2'd2:    par_rdata[4:0]  = {frame_err, overrun, rx_valid, fifo_full, tx_busy};
            2'd3:    par_rdata[15:0] = div_reg;
            default: par_rdata       = '0;
        endcase
    end

    assign rx_irq = rx_valid;

endmodule

// File: tb/tb_xpar_uart.sv
// tb/tb_xpar_uart.sv - directed self-checking bench for xpar_uart
module tb_xpar_uart;
    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] par_addr;
    logic [31:0] par_wdata;
    logic        par_we, par_re;
    logic [31:0] par_rdata;
    logic        uart_tx, uart_rx, rx_irq;
    logic        loop, rx_line;
    int          checks = 0;
    int          errors = 0;
    logic [9:0]  fr [5];
    logic [9:0]  a5_frame;

    assign uart_rx = loop ? uart_tx : rx_line;

    xpar_uart dut (
        .clk(clk), .rst(rst), .par_addr(par_addr), .par_wdata(par_wdata),
        .par_we(par_we), .par_re(par_re), .par_rdata(par_rdata),
        .uart_tx(uart_tx), .uart_rx(uart_rx), .rx_irq(rx_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        par_addr = a; par_wdata = d; par_we = 1'b1;
        @(negedge clk);
        par_we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        par_addr = a;
        #1;
        chk(tag, par_rdata, exp);
    endtask

    task automatic rd_clear();
        par_addr = 12'd1; par_re = 1'b1;
        @(negedge clk);
        par_re = 1'b0;
    endtask

    task automatic wait_irq(input int budget);
        int n = 0;
        while (!rx_irq && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic send_rx(input logic [9:0] bits);
        for (int b = 0; b < 10; b++) begin
            rx_line = bits[b];
            repeat (8) @(negedge clk);
        end
        rx_line = 1'b1;
    endtask

    initial begin
        rst = 1'b1; par_addr = '0; par_wdata = '0; par_we = 1'b0; par_re = 1'b0;
        loop = 1'b0; rx_line = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_uart_tx", uart_tx, 1);
        chk("rst_rx_irq", rx_irq, 0);
        rd_chk("rst_status", 12'd2, 32'h0);
        rd_chk("rst_div", 12'd3, 32'd434);
        rd_chk("rst_txdata_read", 12'd0, 32'h0);

        // Single frame of 0xA5 at DIV=4
        wr(12'd3, 32'd4);
        rd_chk("div4", 12'd3, 32'd4);
        wr(12'd0, 32'hA5);
        chk("tx_idle_at_write_edge", uart_tx, 1);
        a5_frame = {1'b1, 8'hA5, 1'b0};
        par_addr = 12'd2;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("a5_bit", uart_tx, a5_frame[i/4]);
            if (i == 20) chk("tx_busy_mid", par_rdata, 32'h1);
        end
        @(negedge clk);
        rd_chk("tx_busy_after", 12'd2, 32'h0);

        // Five back-to-back pushes, then a push into a full FIFO
        for (int k = 0; k < 5; k++) fr[k] = {1'b1, 8'(k + 1), 1'b0};
        @(negedge clk);
        par_addr = 12'd0; par_wdata = 32'd1; par_we = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            par_wdata = k;
        end
        @(negedge clk);
        par_we = 1'b0;
        rd_chk("fifo_full", 12'd2, 32'h3);
        for (int i = 3; i < 210; i++) begin
            if (i == 4) begin par_addr = 12'd0; par_wdata = 32'h6; par_we = 1'b1; end
            if (i == 5) begin par_we = 1'b0; par_addr = 12'd2; end
            chk("tx_stream", uart_tx, (i < 200) ? fr[i/40][(i%40)/4] : 1'b1);
            @(negedge clk);
        end
        rd_chk("stream_done", 12'd2, 32'h0);

        // Loopback reception
        loop = 1'b1;
        wr(12'd3, 32'd8);
        wr(12'd0, 32'h3C);
        wait_irq(300);
        chk("lb_irq", rx_irq, 1);
        rd_chk("lb_rxdata", 12'd1, 32'h13C);
        rd_clear();
        #1;
        chk("lb_rxdata_cleared", par_rdata, 32'h03C);
        chk("lb_irq_cleared", rx_irq, 0);
        repeat (40) @(negedge clk);

        // Overrun
        wr(12'd0, 32'h11);
        wr(12'd0, 32'h22);
        repeat (220) @(negedge clk);
        rd_chk("ovr_rxdata", 12'd1, 32'h122);
        rd_chk("ovr_status", 12'd2, 32'h0C);
        wr(12'd2, 32'h08);
        rd_chk("ovr_cleared", 12'd2, 32'h04);
        rd_clear();
        rd_chk("rx_drained", 12'd2, 32'h0);
        loop = 1'b0;

        // Direct-driven frames: good, bad stop, glitch (aliased addresses)
        send_rx({1'b1, 8'h5A, 1'b0});
        repeat (10) @(negedge clk);
        rd_chk("good_rxdata", 12'h005, 32'h15A);
        rd_chk("good_status", 12'd2, 32'h04);
        send_rx({1'b0, 8'h33, 1'b0});
        repeat (10) @(negedge clk);
        rd_chk("ferr_status", 12'd2, 32'h14);
        rd_chk("ferr_rxdata_kept", 12'd1, 32'h15A);
        wr(12'd2, 32'h10);
        rd_chk("ferr_cleared", 12'd2, 32'h04);
        rx_line = 1'b0;
        @(negedge clk);
        rx_line = 1'b1;
        repeat (100) @(negedge clk);
        rd_chk("glitch_status", 12'd2, 32'h04);
        rd_chk("glitch_rxdata", 12'd1, 32'h15A);

        // Reset in the middle of a frame
        wr(12'd0, 32'h00);
        wr(12'd0, 32'h00);
        repeat (10) @(negedge clk);
        chk("pre_rst_tx_low", uart_tx, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_uart_tx", uart_tx, 1);
        chk("mid_rst_irq", rx_irq, 0);
        rd_chk("mid_rst_status", 12'd2, 32'h0);
        rd_chk("mid_rst_div", 12'h7, 32'd434);
        repeat (50) @(negedge clk);
        chk("post_rst_tx_idle", uart_tx, 1);
        wr(12'd3, 32'd0);
        rd_chk("div_zero_clamp", 12'd3, 32'd2);
        wr(12'd3, 32'd1);
        rd_chk("div_one_clamp", 12'd3, 32'd2);
        wr(12'd3, 32'h12345);
        rd_chk("div_16bit", 12'd3, 32'h2345);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
